// File: rtl/led_pwm_pkg.sv
// LED PWM controller shared definitions: register map,
// control field positions and parameter limits.
package led_pwm_pkg;

   localparam logic [5:0] ADDR_CTRL       = 6'd0;
   localparam logic [5:0] ADDR_STATIC     = 6'd1;
   localparam logic [5:0] ADDR_MODE       = 6'd2;
   localparam logic [5:0] ADDR_PRESCALE   = 6'd3;
   localparam logic [5:0] ADDR_BLINK_HALF = 6'd4;
   localparam logic [5:0] ADDR_DUTY_BASE  = 6'd8;

   localparam int CTRL_ENABLE   = 0;
   localparam int CTRL_BLINK_EN = 1;
   localparam int CTRL_BITS     = 2;
   localparam int BLINK_BITS    = 32;

   localparam int N_LEDS_MIN   = 1;
   localparam int N_LEDS_MAX   = 32;
   localparam int PWM_BITS_MIN = 4;
   localparam int PWM_BITS_MAX = 16;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: pending/active duty pair and comparator.
// Active duty only changes on the load strobe (frame boundary).
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                we,
   input  logic [PWM_BITS-1:0] wdata,
   input  logic                load,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic [PWM_BITS-1:0] pending,
   output logic                pwm_out
);

   logic [PWM_BITS-1:0] active;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pending <= '0;
         active  <= '0;
      end else begin
         if (we)   pending <= wdata;
         if (load) active  <= pending;
      end
   end

   assign pwm_out = (pwm_cnt < active);

endmodule

// File: rtl/led_pwm_controller.sv
// Avalon-MM LED controller: per-channel static or PWM drive
// with a shared prescaler, frame counter and global blink.
module led_pwm_controller
   import led_pwm_pkg::*;
#(
   parameter int N_LEDS     = 8,
   parameter int PWM_BITS   = 8,
   parameter int PRESC_BITS = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [5:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic [N_LEDS-1:0] leds_out
);

   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

   logic [CTRL_BITS-1:0]  ctrl_r;
   logic [N_LEDS-1:0]     static_r;
   logic [N_LEDS-1:0]     mode_r;
   logic [PRESC_BITS-1:0] presc_r;
   logic [BLINK_BITS-1:0] blink_half;
   logic [PRESC_BITS-1:0] presc_cnt;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic [BLINK_BITS-1:0] blink_cnt;
   logic                  phase;
   logic                  enable;
   logic                  blink_en;
   logic                  tick;
   logic                  frame_end;
   logic                  wr_presc;
   logic                  load;
   logic [N_LEDS-1:0]     duty_we;
   logic [N_LEDS-1:0]     pwm_raw;
   logic [N_LEDS-1:0]     raw;
   logic [PWM_BITS-1:0]   pending [N_LEDS];
   logic [31:0]           rd_data;

   assign enable    = ctrl_r[CTRL_ENABLE];
   assign blink_en  = ctrl_r[CTRL_BLINK_EN];
   assign wr_presc  = avs_write && (avs_address == ADDR_PRESCALE);
   assign tick      = enable && (presc_cnt >= presc_r);
   assign frame_end = tick && (pwm_cnt == PWM_MAX);
   // While disabled the active duties track pending, so enabling
   // starts the first frame with the latest written values.
   assign load      = frame_end || !enable;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ctrl_r     <= '0;
         static_r   <= '0;
         mode_r     <= '0;
         presc_r    <= '0;
         blink_half <= '0;
      end else if (avs_write) begin
         case (avs_address)
            ADDR_CTRL:       ctrl_r     <= avs_writedata[CTRL_BITS-1:0];
            ADDR_STATIC:     static_r   <= avs_writedata[N_LEDS-1:0];
            ADDR_MODE:       mode_r     <= avs_writedata[N_LEDS-1:0];
            ADDR_PRESCALE:   presc_r    <= avs_writedata[PRESC_BITS-1:0];
            ADDR_BLINK_HALF: blink_half <= avs_writedata[BLINK_BITS-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (!enable) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else begin
         if (wr_presc || tick) presc_cnt <= '0;
         else                  presc_cnt <= presc_cnt + 1'b1;
         if (tick) pwm_cnt <= pwm_cnt + 1'b1;
         if (frame_end) begin
            if (blink_cnt >= blink_half) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
      assign duty_we[i] = avs_write &&
                          (avs_address == 6'(ADDR_DUTY_BASE + i));
      led_pwm_channel #(
         .PWM_BITS(PWM_BITS)
      ) u_ch (
         .clk_clk       (clk_clk),
         .reset_reset_n (reset_reset_n),
         .we            (duty_we[i]),
         .wdata         (avs_writedata[PWM_BITS-1:0]),
         .load          (load),
         .pwm_cnt       (pwm_cnt),
         .pending       (pending[i]),
         .pwm_out       (pwm_raw[i])
      );
   end

   always_comb begin
      rd_data = '0;
      case (avs_address)
         ADDR_CTRL:       rd_data = 32'(ctrl_r);
         ADDR_STATIC:     rd_data = 32'(static_r);
         ADDR_MODE:       rd_data = 32'(mode_r);
         ADDR_PRESCALE:   rd_data = 32'(presc_r);
         ADDR_BLINK_HALF: rd_data = 32'(blink_half);
         default: begin
            for (int i = 0; i < N_LEDS; i++) begin
               if (avs_address == 6'(ADDR_DUTY_BASE + i))
                  rd_data = 32'(pending[i]);
            end
         end
      endcase
   end

   assign raw = (mode_r & pwm_raw) | (~mode_r & static_r);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         avs_readdata <= '0;
         leds_out     <= '0;
      end else begin
         if (avs_read) avs_readdata <= rd_data;
         if (enable && !(blink_en && !phase)) leds_out <= raw;
         else                                 leds_out <= '0;
      end
   end

endmodule

// File: tb/tb_led_pwm_controller.sv
// Self-checking bench for led_pwm_controller: register table,
// read scoreboard and cycle-exact PWM/blink sequences.
module tb_led_pwm_controller;

   typedef struct {
      logic [5:0]  a;
      logic [31:0] wd;
      logic [31:0] ex;
   } vec_t;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic [5:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic [7:0]  leds_out;

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];
   vec_t vecs[14];

   always #5 clk_clk = ~clk_clk;

   led_pwm_controller #(
      .N_LEDS(8), .PWM_BITS(8), .PRESC_BITS(16)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .leds_out      (leds_out)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] ex);
      n_checks++;
      if (act !== ex) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, ex);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_clk);
      reset_reset_n = 1'b0;
      avs_read = 1'b0;
      avs_write = 1'b0;
      repeat (3) @(negedge clk_clk);
      reset_reset_n = 1'b1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk_clk);
      avs_address = a;
      avs_writedata = d;
      avs_write = 1'b1;
      @(negedge clk_clk);
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, input logic [31:0] ex,
                     input string name);
      @(negedge clk_clk);
      avs_address = a;
      avs_read = 1'b1;
      exp_q.push_back(ex);
      @(negedge clk_clk);
      avs_read = 1'b0;
      check(name, avs_readdata, exp_q.pop_front());
   endtask

   initial begin
      int mism, hi0, hi1, lows, first_low, other;
      logic expb;
      logic [7:0] expv;

      vecs[0]  = '{6'd0,  32'hFFFF_FFFE, 32'h0000_0002};
      vecs[1]  = '{6'd1,  32'h1234_56A5, 32'h0000_00A5};
      vecs[2]  = '{6'd2,  32'hFFFF_FF0F, 32'h0000_000F};
      vecs[3]  = '{6'd3,  32'hABCD_1234, 32'h0000_1234};
      vecs[4]  = '{6'd4,  32'h0000_0007, 32'h0000_0007};
      vecs[5]  = '{6'd8,  32'hFFFF_FF40, 32'h0000_0040};
      vecs[6]  = '{6'd15, 32'h0000_01FF, 32'h0000_00FF};
      vecs[7]  = '{6'd16, 32'h0000_DEAD, 32'h0000_0000};
      vecs[8]  = '{6'd5,  32'h0000_1234, 32'h0000_0000};
      vecs[9]  = '{6'd63, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[10] = '{6'd7,  32'h0000_0055, 32'h0000_0000};
      vecs[11] = '{6'd9,  32'h0000_003C, 32'h0000_003C};
      vecs[12] = '{6'd8,  32'h0000_0000, 32'h0000_0040};
      vecs[13] = '{6'd1,  32'h0000_0000, 32'h0000_00A5};

      // reset and full address sweep
      repeat (3) @(negedge clk_clk);
      check("rst_leds", 32'(leds_out), 32'h0);
      check("rst_rdata", avs_readdata, 32'h0);
      reset_reset_n = 1'b1;
      for (int a = 0; a < 64; a++) rd(6'(a), 32'h0, "rd_after_rst");
      check("leds_idle", 32'(leds_out), 32'h0);

      // register table; last two entries only re-read
      for (int i = 0; i < 14; i++) begin
         if (i < 12) wr(vecs[i].a, vecs[i].wd);
         rd(vecs[i].a, vecs[i].ex, $sformatf("reg_tbl_%0d", i));
      end
      check("leds_disabled", 32'(leds_out), 32'h0);

      // same-cycle read and write returns the old value
      @(negedge clk_clk);
      avs_address = 6'd1;
      avs_writedata = 32'h3C;
      avs_read = 1'b1;
      avs_write = 1'b1;
      exp_q.push_back(32'hA5);
      @(negedge clk_clk);
      avs_read = 1'b0;
      avs_write = 1'b0;
      check("rw_same_cycle", avs_readdata, exp_q.pop_front());
      rd(6'd1, 32'h3C, "rw_after");
      repeat (3) @(negedge clk_clk);
      check("rdata_hold", avs_readdata, 32'h3C);

      // static write latency
      do_reset();
      wr(6'd0, 32'h1);
      @(negedge clk_clk);
      avs_address = 6'd1;
      avs_writedata = 32'hA5;
      avs_write = 1'b1;
      @(negedge clk_clk);
      avs_write = 1'b0;
      check("static_edge_n", 32'(leds_out), 32'h0);
      @(negedge clk_clk);
      check("static_edge_n1", 32'(leds_out), 32'hA5);

      // PWM 64/256 with glitch-free mid-frame update to 192
      do_reset();
      wr(6'd3, 32'd0);
      wr(6'd2, 32'h01);
      wr(6'd8, 32'd64);
      wr(6'd0, 32'h1);
      mism = 0; hi0 = 0; hi1 = 0;
      for (int k = 0; k < 512; k++) begin
         @(negedge clk_clk);
         expb = ((k % 256) < ((k < 256) ? 64 : 192));
         if (leds_out[0] !== expb) mism++;
         if (leds_out[0] === 1'b1) begin
            if (k < 256) hi0++;
            else         hi1++;
         end
         if (k == 100) begin
            avs_address = 6'd8;
            avs_writedata = 32'd192;
            avs_write = 1'b1;
         end
         if (k == 101) avs_write = 1'b0;
      end
      check("pwm64_high", 32'(hi0), 32'd64);
      check("pwm192_high", 32'(hi1), 32'd192);
      check("pwm_glitch_mism", 32'(mism), 32'd0);

      // duty 0 and duty 255 extremes
      do_reset();
      wr(6'd3, 32'd0);
      wr(6'd2, 32'h01);
      wr(6'd8, 32'd0);
      wr(6'd0, 32'h1);
      hi0 = 0;
      for (int k = 0; k < 512; k++) begin
         @(negedge clk_clk);
         if (leds_out !== 8'h00) hi0++;
      end
      check("duty0_high", 32'(hi0), 32'd0);
      wr(6'd0, 32'h0);
      @(negedge clk_clk);
      check("disable_leds", 32'(leds_out), 32'h0);
      wr(6'd8, 32'd255);
      wr(6'd0, 32'h1);
      lows = 0; first_low = -1; other = 0;
      for (int k = 0; k < 512; k++) begin
         @(negedge clk_clk);
         if (leds_out[0] !== 1'b1) begin
            lows++;
            if (first_low < 0) first_low = k;
         end
         if (leds_out[7:1] !== 7'h0) other++;
      end
      check("duty255_lows", 32'(lows), 32'd2);
      check("duty255_pos", 32'(first_low), 32'd255);
      check("static_others", 32'(other), 32'd0);

      // prescaler 3: four cycles per count
      do_reset();
      wr(6'd3, 32'd3);
      wr(6'd2, 32'h01);
      wr(6'd8, 32'd64);
      wr(6'd0, 32'h1);
      mism = 0; hi0 = 0;
      for (int k = 0; k < 1024; k++) begin
         @(negedge clk_clk);
         expb = ((k / 4) < 64);
         if (leds_out[0] !== expb) mism++;
         if (leds_out[0] === 1'b1) hi0++;
      end
      check("presc3_high", 32'(hi0), 32'd256);
      check("presc3_mism", 32'(mism), 32'd0);

      // blink with BLINK_HALF=1: 512 cycles on, 512 off
      do_reset();
      wr(6'd0, 32'h3);
      mism = 0;
      for (int k = 0; k < 1536; k++) begin
         @(negedge clk_clk);
         expv = ((k >= 6) ? 8'hFF : 8'h00) &
                ((((k / 512) % 2) == 0) ? 8'hFF : 8'h00);
         if (leds_out !== expv) mism++;
         if (k == 511)  check("blink_511", 32'(leds_out), 32'hFF);
         if (k == 512)  check("blink_512", 32'(leds_out), 32'h00);
         if (k == 1023) check("blink_1023", 32'(leds_out), 32'h00);
         if (k == 1024) check("blink_1024", 32'(leds_out), 32'hFF);
         avs_write = 1'b0;
         if (k == 0) begin
            avs_address = 6'd4; avs_writedata = 32'd1; avs_write = 1'b1;
         end
         if (k == 2) begin
            avs_address = 6'd3; avs_writedata = 32'd0; avs_write = 1'b1;
         end
         if (k == 4) begin
            avs_address = 6'd1; avs_writedata = 32'hFF; avs_write = 1'b1;
         end
      end
      avs_write = 1'b0;
      check("blink_mism", 32'(mism), 32'd0);

      // asynchronous reset mid-frame
      rd(6'd1, 32'hFF, "pre_rst_static");
      @(negedge clk_clk);
      #2 reset_reset_n = 1'b0;
      #1;
      check("async_rst_leds", 32'(leds_out), 32'h0);
      check("async_rst_rdata", avs_readdata, 32'h0);
      repeat (2) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      rd(6'd0, 32'h0, "post_rst_ctrl");
      rd(6'd1, 32'h0, "post_rst_static");
      rd(6'd2, 32'h0, "post_rst_mode");
      rd(6'd3, 32'h0, "post_rst_presc");
      rd(6'd4, 32'h0, "post_rst_blink");
      rd(6'd8, 32'h0, "post_rst_duty0");
      check("post_rst_leds", 32'(leds_out), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
